// File: rtl/regbank_bist_if.sv
// regbank_bist_if
// Bus between the register-bank BIST initiator and the 32x32 register bank.
//   master (BIST side): drives wr, dr, wrData, sr1, sr2; reads rdData1, rdData2
//   slave  (bank side): the reverse
// Signals:
//   wr       write enable
//   dr       write address
//   wrData   write data
//   sr1/sr2  read addresses for the two read ports
//   rdData1  read data for sr1 (combinational from the bank)
//   rdData2  read data for sr2 (combinational from the bank)
interface regbank_bist_if;
  logic        wr;
  logic [4:0]  dr;
  logic [31:0] wrData;
  logic [4:0]  sr1;
  logic [4:0]  sr2;
  logic [31:0] rdData1;
  logic [31:0] rdData2;

  modport master (
    output wr, dr, wrData, sr1, sr2,
    input  rdData1, rdData2
  );

  modport slave (
    input  wr, dr, wrData, sr1, sr2,
    output rdData1, rdData2
  );
endinterface

// File: rtl/regbank_bist.sv
// regbank_bist
// Built-in self-test initiator for the 32x32 dual-read/single-write register
// bank. On start it writes k*STEP into register k for all 32 registers, then
// reads them back two per cycle and reports the error count and the address
// of the first mismatching word.
//
// Optional feature (macro REGBANK_BIST_INV_PASS_EN): after the normal pass a
// second write/check pass runs with the inverted pattern, accumulating into
// the same error count and first-fail address.
//
// Parameters:
//   STEP      pattern increment, register k holds k*STEP (32-bit truncated)
//   CHECK_R0  0 = ignore mismatches at address 0 (hardwired-zero r0 banks)
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      single-cycle request to begin a test (ignored while busy)
//   bus        master side of the bank bus (write port, two read ports)
//   busy       test in progress; the bank ports are owned while high
//   done       test finished; held until the next accepted start or reset
//   pass       done with zero errors
//   err_count  mismatching words, saturating at 127
//   fail_addr  address of the first mismatch, 0 if none
module regbank_bist #(
  parameter logic [31:0] STEP     = 32'd10,
  parameter bit          CHECK_R0 = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  regbank_bist_if.master        bus,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [6:0]            err_count,
  output logic [4:0]            fail_addr
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    CHECK,
    DONE
`ifdef REGBANK_BIST_INV_PASS_EN
    ,
    WRITE_INV,
    CHECK_INV
`endif
  } state_t;

  state_t      state;
  logic [4:0]  k;

  logic        wrReg;
  logic [4:0]  drReg;
  logic [31:0] wrDataReg;
  logic [4:0]  sr1Reg;
  logic [4:0]  sr2Reg;

  logic        writing;
  logic        checking;
  logic        invPhase;
  logic [31:0] invMask;
  logic [4:0]  kNext;
  logic [31:0] expected1;
  logic [31:0] expected2;
  logic        miss1;
  logic        miss2;
  logic [7:0]  errSum;
  logic [6:0]  errNext;

  function automatic logic [31:0] pattern(input logic [4:0] idx);
    return {27'd0, idx} * STEP;
  endfunction

  assign bus.wr     = wrReg;
  assign bus.dr     = drReg;
  assign bus.wrData = wrDataReg;
  assign bus.sr1    = sr1Reg;
  assign bus.sr2    = sr2Reg;

  // Phase decode plus the compare datapath. The read data is combinational
  // from the bank, so the words addressed by sr1/sr2 this cycle are compared
  // against the pattern of k and k+1 on the coming edge. Address 0 only ever
  // appears on read port 1, so the r0 mask is needed there alone. The error
  // sum is one bit wider than the counter so saturation can be detected.
  always_comb begin
    writing  = (state == WRITE);
    checking = (state == CHECK);
    invPhase = 1'b0;
`ifdef REGBANK_BIST_INV_PASS_EN
    writing  = writing  || (state == WRITE_INV);
    checking = checking || (state == CHECK_INV);
    invPhase = (state == WRITE_INV) || (state == CHECK_INV);
`endif
    invMask   = {32{invPhase}};
    kNext     = k + 5'd1;
    expected1 = pattern(k) ^ invMask;
    expected2 = pattern(kNext) ^ invMask;
    miss1     = checking && (bus.rdData1 != expected1) && (CHECK_R0 || (k != 5'd0));
    miss2     = checking && (bus.rdData2 != expected2);
    errSum    = {1'b0, err_count} + {7'd0, miss1} + {7'd0, miss2};
    errNext   = errSum[7] ? 7'd127 : errSum[6:0];
  end

  // Test sequencer. Every bank-facing output is registered here so the bank
  // sees clean addresses a full cycle before each write or compare edge.
  // Leaving a write phase preloads sr1/sr2 with the first pair so the check
  // phase can compare on its very first edge. fail_addr only latches while
  // the count is still zero, i.e. on the first failing edge of the run, and
  // port 1 (the lower address) takes priority on that edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      k         <= 5'd0;
      wrReg     <= 1'b0;
      drReg     <= 5'd0;
      wrDataReg <= 32'd0;
      sr1Reg    <= 5'd0;
      sr2Reg    <= 5'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= 7'd0;
      fail_addr <= 5'd0;
    end else if ((state == IDLE) || (state == DONE)) begin
      if (start) begin
        state     <= WRITE;
        k         <= 5'd0;
        busy      <= 1'b1;
        done      <= 1'b0;
        pass      <= 1'b0;
        err_count <= 7'd0;
        fail_addr <= 5'd0;
        wrReg     <= 1'b1;
        drReg     <= 5'd0;
        wrDataReg <= pattern(5'd0);
      end
    end else if (writing) begin
      if (k == 5'd31) begin
        state  <= CHECK;
`ifdef REGBANK_BIST_INV_PASS_EN
        if (state == WRITE_INV) begin
          state <= CHECK_INV;
        end
`endif
        k      <= 5'd0;
        wrReg  <= 1'b0;
        sr1Reg <= 5'd0;
        sr2Reg <= 5'd1;
      end else begin
        k         <= kNext;
        drReg     <= kNext;
        wrDataReg <= pattern(kNext) ^ invMask;
      end
    end else if (checking) begin
      err_count <= errNext;
      if ((err_count == 7'd0) && (miss1 || miss2)) begin
        fail_addr <= miss1 ? k : kNext;
      end
      if (k == 5'd30) begin
        state <= DONE;
        busy  <= 1'b0;
        done  <= 1'b1;
        pass  <= (errNext == 7'd0);
`ifdef REGBANK_BIST_INV_PASS_EN
        if (state == CHECK) begin
          state     <= WRITE_INV;
          busy      <= 1'b1;
          done      <= 1'b0;
          pass      <= 1'b0;
          k         <= 5'd0;
          wrReg     <= 1'b1;
          drReg     <= 5'd0;
          wrDataReg <= ~pattern(5'd0);
        end
`endif
      end else begin
        k      <= k + 5'd2;
        sr1Reg <= k + 5'd2;
        sr2Reg <= k + 5'd3;
      end
    end else begin
      state <= IDLE;
    end
  end

endmodule

// File: tb/tb_regbank_bist.sv
// tb_regbank_bist
// Self-checking bench for regbank_bist. Two DUTs share clock, reset and
// start: dutA (STEP=10, CHECK_R0=1) carries most scenarios, dutB
// (STEP=7, CHECK_R0=0) is checked in the hardwired-r0 scenario. Each DUT
// has a behavioural bank with an injectable read fault. Expected write
// streams and final results are pushed to queues when start is driven and
// popped when the DUT reports done.
// Fault modes:
//   1 stuck bit: register 7 bit 1 reads 0 (bit 0 of 70 is already 0, so bit 1
//     is the lowest bit the normal pattern actually sets there)
//   2 registers 12 and 13 read with bit 8 flipped
//   3 register 0 reads a hardwired nonzero constant (pattern(0) is always 0,
//     so a constant of 0 could never be seen by the normal pass)
module tb_regbank_bist;

`ifdef REGBANK_BIST_INV_PASS_EN
  localparam int PASSES = 2;
`else
  localparam int PASSES = 1;
`endif
  localparam int TOTAL = 48 * PASSES;
  localparam logic [31:0] STEP_A = 32'd10;
  localparam logic [31:0] STEP_B = 32'd7;
  localparam logic [31:0] R0_CONST = 32'h0000_FFFF;

  typedef struct packed {
    logic [6:0] err;
    logic [4:0] fa;
    logic       ps;
  } result_t;

  logic clk = 1'b0;
  logic rst;
  logic start;
  int   faultMode;

  regbank_bist_if busA ();
  regbank_bist_if busB ();

  logic       busyA, doneA, passA;
  logic [6:0] errA;
  logic [4:0] failA;
  logic       busyB, doneB, passB;
  logic [6:0] errB;
  logic [4:0] failB;

  logic [31:0] memA [32];
  logic [31:0] memB [32];

  result_t     resQ [$];
  logic [36:0] expWrQ [$];
  logic [36:0] obsWrQ [$];

  int compared = 0;
  int mismatched = 0;

  regbank_bist #(.STEP(STEP_A), .CHECK_R0(1'b1)) dutA (
    .clk(clk), .rst(rst), .start(start), .bus(busA),
    .busy(busyA), .done(doneA), .pass(passA),
    .err_count(errA), .fail_addr(failA)
  );

  regbank_bist #(.STEP(STEP_B), .CHECK_R0(1'b0)) dutB (
    .clk(clk), .rst(rst), .start(start), .bus(busB),
    .busy(busyB), .done(doneB), .pass(passB),
    .err_count(errB), .fail_addr(failB)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] faultRead(input int mode, input logic [4:0] a, input logic [31:0] v);
    logic [31:0] r;
    r = v;
    case (mode)
      1: if (a == 5'd7) r[1] = 1'b0;
      2: if ((a == 5'd12) || (a == 5'd13)) r = v ^ 32'h0000_0100;
      3: if (a == 5'd0) r = R0_CONST;
      default: r = v;
    endcase
    return r;
  endfunction

  // Behavioural banks: synchronous write, combinational faulty read.
  always @(posedge clk) begin
    if (busA.wr) memA[busA.dr] <= busA.wrData;
    if (busB.wr) memB[busB.dr] <= busB.wrData;
  end

  assign busA.rdData1 = faultRead(faultMode, busA.sr1, memA[busA.sr1]);
  assign busA.rdData2 = faultRead(faultMode, busA.sr2, memA[busA.sr2]);
  assign busB.rdData1 = faultRead(faultMode, busB.sr1, memB[busB.sr1]);
  assign busB.rdData2 = faultRead(faultMode, busB.sr2, memB[busB.sr2]);

  // Write monitor for dutA, sampled away from the active edge.
  always @(negedge clk) begin
    if (!rst && busA.wr) obsWrQ.push_back({busA.dr, busA.wrData});
  end

  // Reference result: walk every pass and address in compare order.
  function automatic result_t modelRun(input logic [31:0] step, input bit checkR0, input int mode);
    result_t     res;
    int          errs;
    bit          seen;
    logic [31:0] w;
    logic [31:0] r;
    errs = 0;
    seen = 1'b0;
    res.fa = 5'd0;
    for (int p = 0; p < PASSES; p++) begin
      for (int a = 0; a < 32; a++) begin
        w = (32'(a) * step) ^ ((p != 0) ? 32'hFFFF_FFFF : 32'h0);
        r = faultRead(mode, 5'(a), w);
        if ((r !== w) && (checkR0 || (a != 0))) begin
          if (!seen) res.fa = 5'(a);
          seen = 1'b1;
          errs++;
        end
      end
    end
    res.err = (errs > 127) ? 7'd127 : 7'(errs);
    res.ps  = (errs == 0);
    return res;
  endfunction

  task automatic doStart();
    @(negedge clk);
    obsWrQ.delete();
    expWrQ.delete();
    for (int p = 0; p < PASSES; p++) begin
      for (int a = 0; a < 32; a++) begin
        expWrQ.push_back({5'(a), (32'(a) * STEP_A) ^ ((p != 0) ? 32'hFFFF_FFFF : 32'h0)});
      end
    end
    resQ.push_back(modelRun(STEP_A, 1'b1, faultMode));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(output int cycles);
    cycles = 0;
    while (!doneA && cycles < 300) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    faultMode = 0;
    #12;
    compared++;
    if ({busA.wr, busA.dr, busA.wrData, busA.sr1, busA.sr2} !== 48'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_bus: got %h expected 0", {busA.wr, busA.dr, busA.wrData, busA.sr1, busA.sr2});
    end
    compared++;
    if ({busyA, doneA, passA, errA, failA} !== 15'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_status: got %h expected 0", {busyA, doneA, passA, errA, failA});
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    compared++;
    if ({busyA, busA.wr} !== 2'b00) begin
      mismatched++;
      $display("[TB] FAIL idle_quiet: got %b expected 00", {busyA, busA.wr});
    end
  endtask

  task automatic test_clean_run();
    int      cycles;
    result_t exp;
    $display("[TB] clean run");
    faultMode = 0;
    doStart();
    compared++;
    if ({busyA, busA.wr, busA.dr, busA.wrData} !== {1'b1, 1'b1, 5'd0, 32'd0}) begin
      mismatched++;
      $display("[TB] FAIL first_write: got busy=%b wr=%b dr=%0d data=%0d expected 1 1 0 0", busyA, busA.wr, busA.dr, busA.wrData);
    end
    waitDone(cycles);
    compared++;
    if (cycles !== TOTAL) begin
      mismatched++;
      $display("[TB] FAIL clean_latency: got %0d expected %0d", cycles, TOTAL);
    end
    compared++;
    if (obsWrQ.size() !== expWrQ.size()) begin
      mismatched++;
      $display("[TB] FAIL clean_write_count: got %0d expected %0d", obsWrQ.size(), expWrQ.size());
    end
    while (expWrQ.size() > 0 && obsWrQ.size() > 0) begin
      logic [36:0] e;
      logic [36:0] o;
      e = expWrQ.pop_front();
      o = obsWrQ.pop_front();
      compared++;
      if (o !== e) begin
        mismatched++;
        $display("[TB] FAIL clean_write: got dr=%0d data=%0d expected dr=%0d data=%0d", o[36:32], o[31:0], e[36:32], e[31:0]);
      end
    end
    exp = resQ.pop_front();
    compared++;
    if ({errA, failA, passA, busyA} !== {exp.err, exp.fa, exp.ps, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL clean_result: got err=%0d fa=%0d pass=%b busy=%b expected %0d %0d %b 0", errA, failA, passA, busyA, exp.err, exp.fa, exp.ps);
    end
  endtask

  task automatic test_stuck_bit();
    int      cycles;
    result_t exp;
    $display("[TB] stuck bit");
    faultMode = 1;
    doStart();
    waitDone(cycles);
    exp = resQ.pop_front();
    compared++;
    if (cycles !== TOTAL) begin
      mismatched++;
      $display("[TB] FAIL stuck_latency: got %0d expected %0d", cycles, TOTAL);
    end
    compared++;
    if ({errA, failA, passA} !== {exp.err, exp.fa, exp.ps}) begin
      mismatched++;
      $display("[TB] FAIL stuck_result: got err=%0d fa=%0d pass=%b expected %0d %0d %b", errA, failA, passA, exp.err, exp.fa, exp.ps);
    end
  endtask

  task automatic test_back_to_back();
    int      cycles;
    result_t exp;
    $display("[TB] back to back");
    faultMode = 0;
    doStart();
    compared++;
    if ({doneA, passA, errA, failA} !== 14'd0) begin
      mismatched++;
      $display("[TB] FAIL restart_clear: got done=%b pass=%b err=%0d fa=%0d expected all 0", doneA, passA, errA, failA);
    end
    waitDone(cycles);
    exp = resQ.pop_front();
    compared++;
    if ({errA, passA, cycles} !== {exp.err, exp.ps, TOTAL}) begin
      mismatched++;
      $display("[TB] FAIL restart_result: got err=%0d pass=%b cycles=%0d expected %0d %b %0d", errA, passA, cycles, exp.err, exp.ps, TOTAL);
    end
  endtask

  task automatic test_double_fault();
    int      cycles;
    result_t exp;
    $display("[TB] double fault");
    faultMode = 2;
    doStart();
    waitDone(cycles);
    exp = resQ.pop_front();
    compared++;
    if ({errA, failA, passA} !== {exp.err, exp.fa, exp.ps}) begin
      mismatched++;
      $display("[TB] FAIL pair_result: got err=%0d fa=%0d pass=%b expected %0d %0d %b", errA, failA, passA, exp.err, exp.fa, exp.ps);
    end
  endtask

  task automatic test_start_while_busy();
    int      cycles;
    result_t exp;
    $display("[TB] start while busy");
    faultMode = 0;
    doStart();
    repeat (19) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone(cycles);
    cycles = cycles + 20;
    exp = resQ.pop_front();
    compared++;
    if (cycles !== TOTAL) begin
      mismatched++;
      $display("[TB] FAIL busy_start_latency: got %0d expected %0d", cycles, TOTAL);
    end
    compared++;
    if (obsWrQ.size() !== 32 * PASSES) begin
      mismatched++;
      $display("[TB] FAIL busy_start_writes: got %0d expected %0d", obsWrQ.size(), 32 * PASSES);
    end
    compared++;
    if ({errA, passA} !== {exp.err, exp.ps}) begin
      mismatched++;
      $display("[TB] FAIL busy_start_result: got err=%0d pass=%b expected %0d %b", errA, passA, exp.err, exp.ps);
    end
  endtask

  task automatic test_reset_mid_test();
    int      cycles;
    result_t exp;
    $display("[TB] reset mid test");
    faultMode = 0;
    doStart();
    repeat (9) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    compared++;
    if ({busA.wr, busA.dr, busA.wrData, busA.sr1, busA.sr2} !== 48'd0) begin
      mismatched++;
      $display("[TB] FAIL midreset_bus: got %h expected 0", {busA.wr, busA.dr, busA.wrData, busA.sr1, busA.sr2});
    end
    compared++;
    if ({busyA, doneA, passA, errA, failA} !== 15'd0) begin
      mismatched++;
      $display("[TB] FAIL midreset_status: got %h expected 0", {busyA, doneA, passA, errA, failA});
    end
    @(negedge clk);
    rst = 1'b0;
    resQ.delete();
    doStart();
    waitDone(cycles);
    exp = resQ.pop_front();
    compared++;
    if ({errA, passA, cycles} !== {exp.err, exp.ps, TOTAL}) begin
      mismatched++;
      $display("[TB] FAIL midreset_rerun: got err=%0d pass=%b cycles=%0d expected %0d %b %0d", errA, passA, cycles, exp.err, exp.ps, TOTAL);
    end
  endtask

  task automatic test_hardwired_r0();
    int      cycles;
    result_t exp;
    result_t expB;
    $display("[TB] hardwired r0");
    faultMode = 3;
    doStart();
    waitDone(cycles);
    exp = resQ.pop_front();
    expB = modelRun(STEP_B, 1'b0, 3);
    compared++;
    if ({errA, failA, passA} !== {exp.err, exp.fa, exp.ps}) begin
      mismatched++;
      $display("[TB] FAIL r0_checked: got err=%0d fa=%0d pass=%b expected %0d %0d %b", errA, failA, passA, exp.err, exp.fa, exp.ps);
    end
    compared++;
    if ({doneB, errB, failB, passB} !== {1'b1, expB.err, expB.fa, expB.ps}) begin
      mismatched++;
      $display("[TB] FAIL r0_masked: got done=%b err=%0d fa=%0d pass=%b expected 1 %0d %0d %b", doneB, errB, failB, passB, expB.err, expB.fa, expB.ps);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_clean_run();
    test_stuck_bit();
    test_back_to_back();
    test_double_fault();
    test_start_while_busy();
    test_reset_mid_test();
    test_hardwired_r0();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
